// File: rtl/alu_share_scheduler_pkg.sv
// Shared definitions for the ALU share scheduler: ALUOp / Operation / Funct7
// encodings, FSM state type, the request-encoding struct and a Funct3 mapping
// helper used by the decoder.
package alu_share_scheduler_pkg;

  localparam logic [1:0] ALUOP_I  = 2'b00;
  localparam logic [1:0] ALUOP_LS = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  // Instruction encoding fields carried through the grant mux
  typedef struct packed {
    logic [1:0] aluop;
    logic [6:0] funct7;
    logic [2:0] funct3;
  } enc_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] op;
  } dec_t;

  // Funct3 map shared by R-type (base Funct7) and I-type
  function automatic dec_t f3_map(input logic [2:0] f3);
    dec_t d;
    d.ok = 1'b1;
    d.op = OP_ADD;
    case (f3)
      3'b111:  d.op = OP_AND;
      3'b110:  d.op = OP_OR;
      3'b100:  d.op = OP_XOR;
      3'b010:  d.op = OP_SLT;
      3'b000:  d.op = OP_ADD;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_share_scheduler_alu_op_decode.sv
// alu_op_decode: combinational ALUOp/Funct7/Funct3 -> 4-bit Operation decode.
// Ports:
//   aluop, funct7, funct3 : instruction fields of the granted request
//   op                    : Operation code (ADD for any illegal encoding)
//   illegal               : encoding not supported
module alu_op_decode
  import alu_share_scheduler_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] op,
  output logic       illegal
);

  dec_t f3d;
  assign f3d = f3_map(funct3);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b1;
    case (aluop)
      ALUOP_R: begin
        if (funct7 == FUNCT7_BASE && f3d.ok) begin
          op      = f3d.op;
          illegal = 1'b0;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          op      = OP_SUB;
          illegal = 1'b0;
        end
      end
      ALUOP_I: begin
        // Funct7 is immediate bits here, so SUB cannot be expressed
        if (f3d.ok) begin
          op      = f3d.op;
          illegal = 1'b0;
        end
      end
      ALUOP_LS: begin
        if (funct3 == 3'b010) illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// alu_share_scheduler: shares one pipelined ALU between two requesters.
// Round-robin arbiter, op decode, issue register, tracking pipeline that
// routes each result back to its owner, per-requester flush, drain FSM.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   rN_valid/ready              : request handshake (N=0,1)
//   rN_aluop/funct7/funct3      : instruction encoding
//   rN_a, rN_b                  : operands
//   rN_flush                    : kill every in-flight op owned by N
//   alu_valid/op/a/b            : registered issue to the ALU
//   alu_result                  : ALU result, ALU_LAT cycles after alu_valid
//   rsp_valid/data/err          : one-hot owner, result, illegal-encoding flag
//   drain_req / drain_done      : stop granting / nothing left in flight
module alu_share_scheduler
  import alu_share_scheduler_pkg::*;
#(
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [1:0]   r0_aluop,
  input  logic [6:0]   r0_funct7,
  input  logic [2:0]   r0_funct3,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r0_flush,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [1:0]   r1_aluop,
  input  logic [6:0]   r1_funct7,
  input  logic [2:0]   r1_funct3,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  input  logic         r1_flush,
  output logic         alu_valid,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic [1:0]   rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  input  logic         drain_req,
  output logic         drain_done
);

  localparam int STAGES = ALU_LAT;
  localparam int CW     = $clog2(ALU_LAT + 3);

  logic [1:0] req_v, flush, gnt;
  logic       rr_ptr, rr_nxt, grant_en, sel, any_gnt, gnt_kill;
  state_t     state_q, state_d;

  assign req_v = {r1_valid, r0_valid};
  assign flush = {r1_flush, r0_flush};

  // Grants stop in the same cycle drain_req rises and resume in the same
  // cycle it falls; reset also masks them so ready reads 0 during reset.
  assign grant_en = rst_n & ~drain_req;

  always_comb begin
    gnt    = 2'b00;
    rr_nxt = rr_ptr;
    if (grant_en) begin
      case (req_v)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          gnt    = rr_ptr ? 2'b10 : 2'b01;
          rr_nxt = ~rr_ptr;
        end
        default: ;
      endcase
    end
  end

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign sel      = gnt[1];
  assign any_gnt  = |gnt;
  // A grant coinciding with its owner's flush is accepted but never issued
  assign gnt_kill = any_gnt & flush[sel];

  enc_t         enc;
  logic [W-1:0] mux_a, mux_b;
  logic [3:0]   dec_op;
  logic         dec_ill;

  assign enc   = sel ? {r1_aluop, r1_funct7, r1_funct3} : {r0_aluop, r0_funct7, r0_funct3};
  assign mux_a = sel ? r1_a : r0_a;
  assign mux_b = sel ? r1_b : r0_b;

  alu_op_decode u_dec (
    .aluop   (enc.aluop),
    .funct7  (enc.funct7),
    .funct3  (enc.funct3),
    .op      (dec_op),
    .illegal (dec_ill)
  );

  // Tracking pipeline: stage 0 is the issue register, stage STAGES lines up
  // with alu_result.
  logic [STAGES:0] vld_pipe, own_pipe, err_pipe, kill_vec;
  logic            tail_live;
  logic [CW-1:0]   inflight, inflight_nxt, nkill;

  always_comb begin
    kill_vec = '0;
    for (int i = 0; i <= STAGES; i++) kill_vec[i] = vld_pipe[i] & flush[own_pipe[i]];
  end

  assign alu_valid = vld_pipe[0];
  assign tail_live = vld_pipe[STAGES] & ~kill_vec[STAGES];

  always_comb begin
    nkill = CW'(gnt_kill);
    for (int i = 0; i <= STAGES; i++) nkill = nkill + CW'(kill_vec[i]);
    inflight_nxt = inflight + CW'(any_gnt) - CW'(|rsp_valid) - nkill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      inflight  <= '0;
      vld_pipe  <= '0;
      own_pipe  <= '0;
      err_pipe  <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rr_ptr      <= rr_nxt;
      inflight    <= inflight_nxt;
      vld_pipe[0] <= any_gnt & ~gnt_kill;
      own_pipe[0] <= sel;
      err_pipe[0] <= dec_ill;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~kill_vec[i-1];
        own_pipe[i] <= own_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
      if (any_gnt) begin
        alu_op <= dec_op;
        alu_a  <= mux_a;
        alu_b  <= mux_b;
      end
      rsp_valid <= tail_live ? (own_pipe[STAGES] ? 2'b10 : 2'b01) : 2'b00;
      rsp_err   <= tail_live & err_pipe[STAGES];
      if (tail_live) rsp_data <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        drain_done = (inflight == '0);
        if (!drain_req) state_d = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

endmodule
